// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response plus the decode valid/ready stream.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_addr, imem_rd_en, instr_valid, instr, instr_pc,
    input  imem_data, instr_ready
  );

  modport slave (
    input  imem_addr, imem_rd_en, instr_valid, instr, instr_pc,
    output imem_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch buffer: issue-to-instr_valid latency 2 cycles, one fetch per cycle;
// decode backpressure stops issue once buffered + in-flight fetches reach FIFO_DEPTH.
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP    = ADDR_W'(1),
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              has_credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_vld;
  entry_t            head;

  // The in-flight fetch already owns a slot, so it is charged against the credit.
  assign has_credit = (count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
  assign issue      = ~reset & (state == RUN) & fetch_en & ~redirect_valid & has_credit;
  assign push       = ~reset & inflight & ~redirect_valid;
  assign head_vld   = ~reset & (count != '0);
  assign pop        = head_vld & bus.instr_ready & ~redirect_valid;
  assign head       = fifo_mem[rd_ptr];

  assign bus.imem_rd_en  = issue;
  assign bus.imem_addr   = reset ? RESET_PC : pc;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = head_vld ? head.instr : '0;
  assign bus.instr_pc    = head_vld ? head.pc    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + PC_STEP;
      end

      inflight <= issue;
      if (issue) begin
        issued_pc <= pc;
      end
    end
  end

  // Redirect flushes the buffer; a pop or capture in the same cycle is moot.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: issued_pc, instr: bus.imem_data};
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random stimulus for instr_fetch_unit, checked each cycle against a queue-based model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  // Registered memory; junk on idle cycles so a mistimed capture is visible.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_data <= mem_word(bus.imem_addr);
    else                bus.imem_data <= $urandom;
  end

  // Reference: fetch allowed flag, next PC, the fetch whose data is on the bus next cycle,
  // and the ordered list of fetched {pc, instr} awaiting decode.
  logic        m_run;
  logic [31:0] m_pc;
  logic [31:0] pend[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic fe, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    logic        e_issue;
    logic        e_vld;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
    reset          = rst;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.instr_ready = rdy;
    @(negedge clk);
    e_issue = !rst && m_run && fe && !rv && ((q_pc.size() + pend.size()) < 4);
    e_vld   = !rst && (q_pc.size() != 0);
    e_ipc   = e_vld ? q_pc[0] : 32'h0;
    e_ins   = e_vld ? q_in[0] : 32'h0;
    chk("imem_rd_en",  32'(bus.imem_rd_en),  32'(e_issue));
    chk("imem_addr",   bus.imem_addr,        rst ? 32'h0 : m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(e_vld));
    chk("instr",       bus.instr,            e_ins);
    chk("instr_pc",    bus.instr_pc,         e_ipc);
    if (rst) begin
      m_pc = 32'h0;
      pend.delete(); q_pc.delete(); q_in.delete();
    end else if (rv) begin
      m_pc = rpc;
      pend.delete(); q_pc.delete(); q_in.delete();
    end else begin
      if (e_vld && rdy) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (pend.size() != 0) begin
        q_pc.push_back(pend[0]);
        q_in.push_back(mem_word(pend[0]));
      end
      pend.delete();
      if (e_issue) begin
        pend.push_back(m_pc);
        m_pc = m_pc + 32'h1;
      end
    end
    m_run = rst ? 1'b0 : fe;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.instr_ready = 1'b0;
    m_run = 1'b0; m_pc = 32'h0;
    @(posedge clk);
    #1;

    // Reset, then a free-running stream.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Decode stalls: buffer fills, issue stops, then drains in order.
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect mid-stream.
    cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b1);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with a pop while the buffer is full.
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // PC wrap.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Reset with a fetch in flight.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // fetch_en dropped mid-stream, redirect while idle, resume.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic        r_fe;
      logic        r_rv;
      logic        r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) == 0);
      r_fe  = ($urandom_range(0, 7) != 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 1) == 1);
      r_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle(r_rst, r_fe, r_rv, r_pc, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
